// File: rtl/grid_io_tile_multi.sv
// Multi-channel perimeter IO tile: a ccff scan chain feeds a shadow register that is committed to the pads.
// Define CFG_PARITY_EN to append an even-parity bit to the chain and check it on commit.
module grid_io_tile_multi #(
  parameter int NUM_IO    = 4,
  parameter int MODE_BITS = 2
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              IO_ISOL_N,
  input  logic              ccff_head,
  output logic              ccff_tail,
  input  logic              cfg_shift_en,
  input  logic              cfg_commit,
  output logic              cfg_done,
  output logic              cfg_err,
  input  logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_IN,
  output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_OUT,
  output logic [NUM_IO-1:0] gfpga_pad_EMBEDDED_IO_HD_SOC_DIR,
  input  logic [NUM_IO-1:0] fabric_outpad,
  input  logic [NUM_IO-1:0] fabric_oe,
  output logic [NUM_IO-1:0] fabric_inpad
);

  localparam int MODE_W = NUM_IO * MODE_BITS;
`ifdef CFG_PARITY_EN
  localparam int PAR_W = 1;
`else
  localparam int PAR_W = 0;
`endif
  localparam int CHAIN_LEN = MODE_W + PAR_W;
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CHAIN_LEN);

  localparam logic [1:0] MODE_OFF  = 2'b00;
  localparam logic [1:0] MODE_IN   = 2'b01;
  localparam logic [1:0] MODE_OUT  = 2'b10;
  localparam logic [1:0] MODE_BIDI = 2'b11;

  logic [CHAIN_LEN-1:0] chain;
  logic [CNT_W-1:0]     cnt;
  logic                 over;
  logic [MODE_W-1:0]    active_mode;
  logic                 parity_ok;
  logic                 commit_ok;

  // Shadow chain: bit 0 takes the serial input, the top bit is the cascade output.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      chain <= '0;
    end else if (cfg_shift_en) begin
      chain <= {chain[CHAIN_LEN-2:0], ccff_head};
    end
  end

  assign ccff_tail = chain[CHAIN_LEN-1];

  // Bit counter saturates at CHAIN_LEN; one shift past that marks the load as overrun.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      cnt  <= '0;
      over <= 1'b0;
    end else if (cfg_commit) begin
      cnt  <= cfg_shift_en ? CNT_W'(1) : '0;
      over <= 1'b0;
    end else if (cfg_shift_en) begin
      if (cnt == CNT_FULL) begin
        over <= 1'b1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign cfg_done = (cnt == CNT_FULL) && !over;

`ifdef CFG_PARITY_EN
  assign parity_ok = ~^chain;
`else
  assign parity_ok = 1'b1;
`endif

  assign commit_ok = cfg_done && parity_ok;

  // Commit reads the pre-shift chain, so a same-cycle shift does not disturb what is applied.
  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      active_mode <= '0;
      cfg_err     <= 1'b0;
    end else if (cfg_commit) begin
      cfg_err <= !commit_ok;
      if (commit_ok) begin
        active_mode <= chain[MODE_W-1:0];
      end
    end
  end

  always_comb begin
    gfpga_pad_EMBEDDED_IO_HD_SOC_DIR = '0;
    gfpga_pad_EMBEDDED_IO_HD_SOC_OUT = '0;
    fabric_inpad                     = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      if (IO_ISOL_N) begin
        case (active_mode[MODE_BITS*k +: 2])
          MODE_IN: begin
            fabric_inpad[k] = gfpga_pad_EMBEDDED_IO_HD_SOC_IN[k];
          end
          MODE_OUT: begin
            gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[k] = 1'b1;
            gfpga_pad_EMBEDDED_IO_HD_SOC_OUT[k] = fabric_outpad[k];
          end
          MODE_BIDI: begin
            gfpga_pad_EMBEDDED_IO_HD_SOC_DIR[k] = fabric_oe[k];
            gfpga_pad_EMBEDDED_IO_HD_SOC_OUT[k] = fabric_outpad[k];
            fabric_inpad[k]                     = gfpga_pad_EMBEDDED_IO_HD_SOC_IN[k];
          end
          MODE_OFF: begin
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_grid_io_tile_multi.sv
// Bench for grid_io_tile_multi: a shift-history model predicts every output on each falling edge.
module tb_grid_io_tile_multi;

  localparam int NUM_IO = 4;
  localparam int MW     = 2 * NUM_IO;
`ifdef CFG_PARITY_EN
  localparam int CL = MW + 1;
`else
  localparam int CL = MW;
`endif

  logic              prog_clk;
  logic              pReset;
  logic              IO_ISOL_N;
  logic              ccff_head;
  logic              ccff_tail;
  logic              cfg_shift_en;
  logic              cfg_commit;
  logic              cfg_done;
  logic              cfg_err;
  logic [NUM_IO-1:0] pad_in;
  logic [NUM_IO-1:0] pad_out;
  logic [NUM_IO-1:0] pad_dir;
  logic [NUM_IO-1:0] outpad;
  logic [NUM_IO-1:0] oe;
  logic [NUM_IO-1:0] inpad;

  int n_checks = 0;
  int n_fail   = 0;

  grid_io_tile_multi #(.NUM_IO(NUM_IO), .MODE_BITS(2)) dut (
    .prog_clk                         (prog_clk),
    .pReset                           (pReset),
    .IO_ISOL_N                        (IO_ISOL_N),
    .ccff_head                        (ccff_head),
    .ccff_tail                        (ccff_tail),
    .cfg_shift_en                     (cfg_shift_en),
    .cfg_commit                       (cfg_commit),
    .cfg_done                         (cfg_done),
    .cfg_err                          (cfg_err),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_IN  (pad_in),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_OUT (pad_out),
    .gfpga_pad_EMBEDDED_IO_HD_SOC_DIR (pad_dir),
    .fabric_outpad                    (outpad),
    .fabric_oe                        (oe),
    .fabric_inpad                     (inpad)
  );

  // Clock / reset
  initial prog_clk = 1'b0;
  always #5 prog_clk = ~prog_clk;

  // Model: bits shifted since reset (newest at back), shifts since last commit, applied modes.
  bit         hist[$];
  int         since = 0;
  bit         m_err = 1'b0;
  logic [1:0] m_act [NUM_IO] = '{default: 2'b00};

  function automatic bit chain_bit(input int i);
    if (i < hist.size()) return hist[hist.size()-1-i];
    return 1'b0;
  endfunction

  function automatic bit m_parity_ok();
`ifdef CFG_PARITY_EN
    bit x = 1'b0;
    for (int i = 0; i < CL; i++) x ^= chain_bit(i);
    return !x;
`else
    return 1'b1;
`endif
  endfunction

  always @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      hist.delete();
      since = 0;
      m_err = 1'b0;
      for (int k = 0; k < NUM_IO; k++) m_act[k] = 2'b00;
    end else begin
      if (cfg_commit) begin
        if (since == CL && m_parity_ok()) begin
          for (int k = 0; k < NUM_IO; k++) m_act[k] = {chain_bit(2*k+1), chain_bit(2*k)};
          m_err = 1'b0;
        end else begin
          m_err = 1'b1;
        end
        since = cfg_shift_en ? 1 : 0;
      end else if (cfg_shift_en) begin
        since++;
      end
      if (cfg_shift_en) begin
        hist.push_back(ccff_head);
        if (hist.size() > CL) void'(hist.pop_front());
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: compare every output against the model on each falling edge.
  always @(negedge prog_clk) begin
    logic [NUM_IO-1:0] e_dir, e_out, e_in;
    e_dir = '0;
    e_out = '0;
    e_in  = '0;
    for (int k = 0; k < NUM_IO; k++) begin
      if (IO_ISOL_N) begin
        case (m_act[k])
          2'd1: e_in[k] = pad_in[k];
          2'd2: begin e_dir[k] = 1'b1; e_out[k] = outpad[k]; end
          2'd3: begin e_dir[k] = oe[k]; e_out[k] = outpad[k]; e_in[k] = pad_in[k]; end
          default: ;
        endcase
      end
    end
    check("sb_dir", pad_dir, e_dir);
    check("sb_out", pad_out, e_out);
    check("sb_inpad", inpad, e_in);
    check("sb_tail", ccff_tail, chain_bit(CL-1));
    check("sb_done", cfg_done, since == CL);
    check("sb_err", cfg_err, m_err);
  end

  // Driver tasks: inputs change 1 time unit after the falling edge.
  task automatic step(input bit sh, input bit hd, input bit cm, input bit rnd);
    cfg_shift_en = sh;
    ccff_head    = hd;
    cfg_commit   = cm;
    if (rnd) begin
      pad_in = NUM_IO'($urandom_range(0, (1 << NUM_IO) - 1));
      outpad = NUM_IO'($urandom_range(0, (1 << NUM_IO) - 1));
      oe     = NUM_IO'($urandom_range(0, (1 << NUM_IO) - 1));
    end
    @(negedge prog_clk);
    #1;
    cfg_shift_en = 1'b0;
    cfg_commit   = 1'b0;
  endtask

  task automatic load_raw(input logic [CL-1:0] v);
    for (int i = CL - 1; i >= 0; i--) step(1'b1, v[i], 1'b0, 1'b1);
  endtask

  task automatic load_modes(input logic [MW-1:0] m);
    logic [CL-1:0] v;
`ifdef CFG_PARITY_EN
    v = {^m, m};
`else
    v = m;
`endif
    load_raw(v);
  endtask

  task automatic set_pads(input logic [NUM_IO-1:0] pi, input logic [NUM_IO-1:0] po,
                          input logic [NUM_IO-1:0] poe);
    pad_in = pi;
    outpad = po;
    oe     = poe;
    #1;
  endtask

  initial begin
    pReset       = 1'b1;
    IO_ISOL_N    = 1'b1;
    ccff_head    = 1'b0;
    cfg_shift_en = 1'b0;
    cfg_commit   = 1'b0;
    pad_in       = '0;
    outpad       = '0;
    oe           = '0;
    repeat (2) @(negedge prog_clk);
    #1;
    pReset = 1'b0;

    // Idle after reset: nothing drives even with active fabric/pad inputs.
    set_pads(4'hF, 4'hF, 4'hF);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    check("rst_dir", pad_dir, 4'h0);
    check("rst_out", pad_out, 4'h0);
    check("rst_inpad", inpad, 4'h0);
    check("rst_done", cfg_done, 1'b0);
    check("rst_err", cfg_err, 1'b0);
    check("rst_tail", ccff_tail, 1'b0);

    // Modes ch3..ch0 = 11,10,01,00.
    load_modes(8'b11_10_01_00);
    check("full_done", cfg_done, 1'b1);
    set_pads(4'b1010, 4'b1100, 4'b1000);
    check("pre_commit_dir", pad_dir, 4'h0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    check("mix_dir", pad_dir, 4'b1100);
    check("mix_out", pad_out, 4'b1100);
    check("mix_inpad", inpad, 4'b1010);
    check("mix_done", cfg_done, 1'b0);
    check("mix_err", cfg_err, 1'b0);

    // Short load rejected, modes unchanged.
    for (int i = 0; i < CL - 1; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("short_err", cfg_err, 1'b1);
    set_pads(4'b1010, 4'b1100, 4'b1000);
    check("short_keep_dir", pad_dir, 4'b1100);
    check("short_keep_inpad", inpad, 4'b1010);

    // Overlong load rejected.
    for (int i = 0; i < CL + 1; i++) step(1'b1, 1'b0, 1'b0, 1'b1);
    check("over_done", cfg_done, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("over_err", cfg_err, 1'b1);

    // Correct reload clears the error.
    load_modes(8'b01_11_00_10);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("reload_err", cfg_err, 1'b0);

    // All outputs, committed in the same cycle as an extra shift.
    load_modes(8'b10_10_10_10);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    check("samecyc_err", cfg_err, 1'b0);
    check("samecyc_done", cfg_done, 1'b0);
    set_pads(4'h0, 4'hF, 4'h0);
    check("allout_dir", pad_dir, 4'hF);
    check("allout_out", pad_out, 4'hF);

    // Isolation blanks pads but the chain keeps shifting.
    IO_ISOL_N = 1'b0;
    #1;
    check("iso_dir", pad_dir, 4'h0);
    check("iso_out", pad_out, 4'h0);
    check("iso_inpad", inpad, 4'h0);
    for (int i = 0; i < 3; i++) step(1'b1, i[0], 1'b0, 1'b1);
    IO_ISOL_N = 1'b1;
    set_pads(4'h0, 4'hF, 4'h0);
    check("deiso_dir", pad_dir, 4'hF);
    check("deiso_out", pad_out, 4'hF);

    // Reset part-way through a load.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 1'b1);
    pReset = 1'b1;
    #1;
    check("midrst_dir", pad_dir, 4'h0);
    check("midrst_out", pad_out, 4'h0);
    check("midrst_tail", ccff_tail, 1'b0);
    check("midrst_done", cfg_done, 1'b0);
    @(negedge prog_clk);
    #1;
    pReset = 1'b0;
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("postrst_err", cfg_err, 1'b1);
    set_pads(4'hF, 4'hF, 4'hF);
    check("postrst_dir", pad_dir, 4'h0);

`ifdef CFG_PARITY_EN
    // Valid parity accepted, then one flipped mode bit rejected.
    load_modes(8'b11_01_10_01);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("par_ok_err", cfg_err, 1'b0);
    load_raw({^8'b11_01_10_01, 8'b11_01_10_00});
    step(1'b0, 1'b0, 1'b1, 1'b1);
    check("par_bad_err", cfg_err, 1'b1);
    set_pads(4'hF, 4'hF, 4'h0);
    check("par_bad_dir", pad_dir, 4'b0010);
    check("par_bad_inpad", inpad, 4'b1101);
`endif

    // Mixed traffic checked by the scoreboard.
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 9) == 0), 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/grid_io_tile_multi.md
Name: grid_io_tile_multi

Overview:
- Parametrised successor of the single-pad IO grid tile: NUM_IO pad channels per tile, each with a 2-bit mode.
- Configuration arrives on the ccff scan chain.
- Config shifts into a shadow chain and is applied to the pads only on an explicit, validated commit, so pads never glitch mid-programming.
- Sits on the FPGA fabric perimeter, between the embedded SoC pad signals and the routing.

Parameters:
NUM_IO, 4, number of pad channels in the tile (1..16)
MODE_BITS, 2, config bits per channel (fixed at 2; kept as a parameter for chain-length arithmetic)

Ports:
prog_clk  input  1  programming clock; the only clock
pReset  input  1  asynchronous, active-high reset
IO_ISOL_N  input  1  global isolation, active low
ccff_head  input  1  config chain serial in
ccff_tail  output  1  config chain serial out
cfg_shift_en  input  1  shift chain by one bit this cycle
cfg_commit  input  1  single-cycle request to apply the shadow chain
cfg_done  output  1  exactly CHAIN_LEN bits shifted since the last commit/reset
cfg_err  output  1  sticky: last commit was rejected
gfpga_pad_EMBEDDED_IO_HD_SOC_IN  input  NUM_IO  pad input from SoC
gfpga_pad_EMBEDDED_IO_HD_SOC_OUT  output  NUM_IO  pad output value
gfpga_pad_EMBEDDED_IO_HD_SOC_DIR  output  NUM_IO  1 = pad driven (output), 0 = input/high-Z
fabric_outpad  input  NUM_IO  data from fabric to pad
fabric_oe  input  NUM_IO  fabric output enable (bidir mode only)
fabric_inpad  output  NUM_IO  data from pad to fabric

Behaviour:
- Chain length:
  - CHAIN_LEN = NUM_IO*MODE_BITS, plus 1 when CFG_PARITY_EN is defined.
- Shift:
  - When cfg_shift_en=1: chain[0]<=ccff_head and chain[i]<=chain[i-1].
  - ccff_tail = chain[CHAIN_LEN-1], registered, so the chain is cascadable.
- Channel k mode:
  - shadow mode = {chain[2k+1], chain[2k]}.
  - active_mode[k] is a separate register, loaded only on an accepted commit.
- Bit counter:
  - Width clog2(CHAIN_LEN+1).
  - Increments on each shift and saturates at CHAIN_LEN.
  - A shift while the count already equals CHAIN_LEN sets an internal `over` flag.
  - cfg_done = (cnt==CHAIN_LEN) && !over.
- Commit (sampled on the prog_clk edge):
  - Accepted iff cfg_done=1 (and parity ok when enabled). Then active_mode <= shadow and cfg_err<=0.
  - Rejected otherwise. Then active_mode is unchanged and cfg_err<=1.
  - In both cases: cnt<=0 and over<=0. If cfg_shift_en=1 in the same cycle, cnt<=1 instead.
  - A same-cycle shift still moves the chain; commit uses the pre-shift chain contents.
- Modes, combinational from active_mode and IO_ISOL_N:
  - 00 disabled: DIR=0, OUT=0, inpad=0.
  - 01 input: DIR=0, OUT=0, inpad=pad_IN.
  - 10 output: DIR=1, OUT=fabric_outpad, inpad=0.
  - 11 bidir: DIR=fabric_oe, OUT=fabric_outpad, inpad=pad_IN.
- Isolation:
  - IO_ISOL_N=0 forces DIR=0, OUT=0, inpad=0 on all channels, regardless of mode.
  - Chain, counter and commit keep operating while isolated.
- Reset (pReset=1, async):
  - chain=0, active_mode=00 on all channels, cnt=0, over=0, cfg_err=0.
  - Outputs during reset: ccff_tail=0, cfg_done=0, DIR=0, OUT=0, inpad=0.
  - Reset mid-shift discards partial config; the first commit after reset without a full shift is rejected.
- Latency:
  - New mode is visible on the pads the cycle after an accepted commit edge.
  - ccff_tail reflects ccff_head after CHAIN_LEN shifts.

Optional Feature:
- Macro: CFG_PARITY_EN.
- With the macro defined:
  - Chain grows by one bit, chain[CHAIN_LEN-1], which carries even parity over all mode bits.
  - Commit is accepted only if XOR over the whole chain == 0; a mismatch rejects the commit and sets cfg_err.
- Without the macro:
  - There is no parity bit and commit checks only the bit count.

Test Plan:
- Reset release, no activity -> all DIR/OUT/inpad=0, cfg_done=0, cfg_err=0, ccff_tail=0.
- NUM_IO=4, shift 8 bits forming modes {11,10,01,00} (ch3..ch0), then commit:
  - cfg_done=1 before commit; pads unchanged until the edge after commit.
  - Then ch1 inpad follows pad_IN; ch2 DIR=1, OUT=fabric_outpad; ch3 DIR=fabric_oe; cfg_done=0.
- Shift 7 bits and commit -> cfg_err=1, active modes unchanged. Shift 9 bits and commit -> over set, rejected, cfg_err=1. Then a correct 8-bit load and commit -> cfg_err=0.
- Set all channels to output mode, drive IO_ISOL_N=0 -> DIR=0, OUT=0, inpad=0. IO_ISOL_N=1 -> prior drive restored with no reprogramming.
- Assert pReset after 5 of 8 shifts -> immediate zero outputs. After release, commit with no shifts -> rejected.
- CFG_PARITY_EN: 9-bit load with correct parity -> accepted. Flip one mode bit -> cfg_err=1, modes unchanged.
